inst_loader: RTL and testbench

Streaming loader that fills the instruction memory of the instruction control stage before execution. It accepts instruction words over a valid/ready stream and produces sequential write strobes (address, data, enable) that connect directly to the instruction-memory write port of the instruction control stage. On completion it can optionally issue a one-cycle start pulse to the core. It sits between the host/DMA-facing CSR/stream interface and the instruction control stage.

---
 rtl/inst_loader_pkg.sv | 9 +
 rtl/inst_load_checksum.sv | 30 +++
 rtl/inst_loader.sv | 188 ++++++++++++++++++
 tb/tb_inst_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared types for the instruction-memory loader.
package inst_loader_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } load_state_e;

endpackage

// File: rtl/inst_load_checksum.sv
// Wrapping accumulator of accepted instruction words, with synchronous clear and enable.
module inst_load_checksum #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] sum_o
);

    logic [Width-1:0] sum_r;

    // Accumulate modulo 2^Width; clear wins over enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_r <= '0;
        end else if (clr_i) begin
            sum_r <= '0;
        end else if (en_i) begin
            sum_r <= sum_r + data_i;
        end else begin
            sum_r <= sum_r;
        end
    end

    assign sum_o = sum_r;

endmodule

// File: rtl/inst_loader.sv
// Streaming loader writing sequential words into the instruction memory.
// Define INST_LOADER_CHECKSUM_EN to build the checksum accumulator.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned RegAddrWidth     = 32,
    parameter int unsigned InstMemDepth     = 128,
    parameter int unsigned InstMemAddrWidth = $clog2(InstMemDepth)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    load_start_i,
    input  logic [RegAddrWidth-1:0] load_base_addr_i,
    input  logic [RegAddrWidth-1:0] load_len_i,
    input  logic                    auto_start_i,
    input  logic [RegAddrWidth-1:0] inst_data_i,
    input  logic                    inst_valid_i,
    output logic                    inst_ready_o,
    output logic [RegAddrWidth-1:0] inst_wr_addr_o,
    output logic [RegAddrWidth-1:0] inst_wr_data_o,
    output logic                    inst_wr_en_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    core_start_o,
    output logic                    err_o,
    output logic [RegAddrWidth-1:0] load_count_o,
    output logic [RegAddrWidth-1:0] checksum_o
);

    load_state_e state_r, state_next_s;

    logic [InstMemAddrWidth-1:0] base_r;
    logic [RegAddrWidth-1:0]     len_r;
    logic [RegAddrWidth-1:0]     count_r;
    logic                        auto_r;
    logic [InstMemAddrWidth-1:0] wr_addr_r;
    logic [RegAddrWidth-1:0]     wr_data_r;
    logic                        wr_en_r;
    logic                        done_r;
    logic                        core_start_r;
    logic                        err_r;

    logic [RegAddrWidth:0]       range_end_s;
    logic                        range_err_s;
    logic [RegAddrWidth-1:0]     len_last_s;
    logic [InstMemAddrWidth-1:0] wr_addr_s;
    logic                        start_load_s;
    logic                        start_zero_s;
    logic                        start_err_s;
    logic                        beat_s;
    logic                        last_beat_s;

    // One extra bit keeps base+len from wrapping past the range check.
    assign range_end_s = {1'b0, load_base_addr_i} + {1'b0, load_len_i};
    assign range_err_s = (range_end_s > (RegAddrWidth + 1)'(InstMemDepth));
    assign len_last_s  = len_r - RegAddrWidth'(1);
    assign wr_addr_s   = base_r + count_r[InstMemAddrWidth-1:0];

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else if (clr_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and start/beat decode.
    always_comb begin
        state_next_s = state_r;
        start_load_s = 1'b0;
        start_zero_s = 1'b0;
        start_err_s  = 1'b0;
        beat_s       = 1'b0;
        last_beat_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (load_start_i) begin
                    if (range_err_s) begin
                        start_err_s = 1'b1;
                    end else if (load_len_i == '0) begin
                        start_zero_s = 1'b1;
                    end else begin
                        start_load_s = 1'b1;
                        state_next_s = LOAD;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                if (inst_valid_i) begin
                    beat_s = 1'b1;
                    if (count_r == len_last_s) begin
                        last_beat_s  = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = LOAD;
                    end
                end else begin
                    state_next_s = LOAD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Load context, write port and completion pulses; clr_i drops everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_r       <= '0;
            len_r        <= '0;
            count_r      <= '0;
            auto_r       <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= '0;
            wr_en_r      <= 1'b0;
            done_r       <= 1'b0;
            core_start_r <= 1'b0;
            err_r        <= 1'b0;
        end else if (clr_i) begin
            base_r       <= '0;
            len_r        <= '0;
            count_r      <= '0;
            auto_r       <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= '0;
            wr_en_r      <= 1'b0;
            done_r       <= 1'b0;
            core_start_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            wr_en_r      <= beat_s;
            done_r       <= last_beat_s | start_zero_s;
            core_start_r <= done_r & auto_r;
            if (beat_s) begin
                wr_addr_r <= wr_addr_s;
                wr_data_r <= inst_data_i;
                count_r   <= count_r + RegAddrWidth'(1);
            end else if (start_load_s || start_zero_s) begin
                base_r  <= load_base_addr_i[InstMemAddrWidth-1:0];
                len_r   <= load_len_i;
                auto_r  <= auto_start_i;
                count_r <= '0;
                err_r   <= 1'b0;
            end else if (start_err_s) begin
                err_r <= 1'b1;
            end else begin
                count_r <= count_r;
            end
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    logic chk_clr_s;

    assign chk_clr_s = clr_i | start_load_s | start_zero_s;

    inst_load_checksum #(
        .Width (RegAddrWidth)
    ) u_checksum (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (chk_clr_s),
        .en_i   (beat_s),
        .data_i (inst_data_i),
        .sum_o  (checksum_o)
    );
`else
    assign checksum_o = '0;
`endif

    assign inst_ready_o   = (state_r == LOAD);
    assign busy_o         = (state_r == LOAD);
    assign inst_wr_addr_o = RegAddrWidth'(wr_addr_r);
    assign inst_wr_data_o = wr_data_r;
    assign inst_wr_en_o   = wr_en_r;
    assign done_o         = done_r;
    assign core_start_o   = core_start_r;
    assign err_o          = err_r;
    assign load_count_o   = count_r;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: directed cases plus randomized loads.
module tb_inst_loader;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
        logic        auto_st;
    } item_t;

`ifdef INST_LOADER_CHECKSUM_EN
    localparam logic [31:0] CkMask = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] CkMask = 32'h0000_0000;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clr_i = 1'b0;
    logic        load_start_i = 1'b0;
    logic [31:0] load_base_addr_i = 32'd0;
    logic [31:0] load_len_i = 32'd0;
    logic        auto_start_i = 1'b0;
    logic [31:0] inst_data_i = 32'd0;
    logic        inst_valid_i = 1'b0;
    logic        inst_ready_o;
    logic [31:0] inst_wr_addr_o;
    logic [31:0] inst_wr_data_o;
    logic        inst_wr_en_o;
    logic        busy_o;
    logic        done_o;
    logic        core_start_o;
    logic        err_o;
    logic [31:0] load_count_o;
    logic [31:0] checksum_o;

    int    total = 0;
    int    bad = 0;
    item_t q[$];
    logic  exp_cs = 1'b0;

    inst_loader dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clr_i            (clr_i),
        .load_start_i     (load_start_i),
        .load_base_addr_i (load_base_addr_i),
        .load_len_i       (load_len_i),
        .auto_start_i     (auto_start_i),
        .inst_data_i      (inst_data_i),
        .inst_valid_i     (inst_valid_i),
        .inst_ready_o     (inst_ready_o),
        .inst_wr_addr_o   (inst_wr_addr_o),
        .inst_wr_data_o   (inst_wr_data_o),
        .inst_wr_en_o     (inst_wr_en_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .core_start_o     (core_start_o),
        .err_o            (err_o),
        .load_count_o     (load_count_o),
        .checksum_o       (checksum_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected item whenever a write strobe or done pulse shows up.
    always @(negedge clk_i) begin
        item_t it;
        if (core_start_o || exp_cs) begin
            check("core_start", {31'd0, core_start_o}, {31'd0, exp_cs});
        end
        exp_cs = 1'b0;
        if (inst_wr_en_o || done_o) begin
            if (q.size() == 0) begin
                check("spurious_strobe", {30'd0, inst_wr_en_o, done_o}, 32'd0);
            end else begin
                it = q.pop_front();
                check("wr_en", {31'd0, inst_wr_en_o}, {31'd0, it.is_write});
                check("done", {31'd0, done_o}, {31'd0, it.last});
                if (it.is_write) begin
                    check("wr_addr", inst_wr_addr_o, it.addr);
                    check("wr_data", inst_wr_data_o, it.data);
                end
                exp_cs = it.last & it.auto_st;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("drain", 32'(q.size()), 32'd0);
        q.delete();
        repeat (2) tick();
    endtask

    task automatic check_idle_clear(input string tag);
        check({tag, "_ready"}, {31'd0, inst_ready_o}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_count"}, load_count_o, 32'd0);
        check({tag, "_cksum"}, checksum_o, 32'd0);
        check({tag, "_wr_en"}, {31'd0, inst_wr_en_o}, 32'd0);
        check({tag, "_done"}, {31'd0, done_o}, 32'd0);
        check({tag, "_cstart"}, {31'd0, core_start_o}, 32'd0);
    endtask

    task automatic do_load(input logic [31:0] base, input logic [31:0] len,
                           input logic auto_st, input int gap, input bit fixed);
        longint unsigned end_v;
        logic [31:0]     w;
        logic [31:0]     sum;
        item_t           it;
        end_v = {32'd0, base} + {32'd0, len};
        sum   = 32'd0;
        load_start_i     = 1'b1;
        load_base_addr_i = base;
        load_len_i       = len;
        auto_start_i     = auto_st;
        tick();
        load_start_i = 1'b0;
        auto_start_i = 1'($urandom_range(0, 1));
        if (end_v > 64'd128) begin
            check("err_set", {31'd0, err_o}, 32'd1);
            check("err_busy", {31'd0, busy_o}, 32'd0);
            repeat (2) tick();
            check("err_ready", {31'd0, inst_ready_o}, 32'd0);
            check("err_sticky", {31'd0, err_o}, 32'd1);
        end else if (len == 32'd0) begin
            it = '{1'b0, 32'd0, 32'd0, 1'b1, auto_st};
            q.push_back(it);
            check("zero_busy", {31'd0, busy_o}, 32'd0);
            wait_drain();
            check("zero_err", {31'd0, err_o}, 32'd0);
        end else begin
            check("start_ready", {31'd0, inst_ready_o}, 32'd1);
            check("start_busy", {31'd0, busy_o}, 32'd1);
            check("start_err", {31'd0, err_o}, 32'd0);
            for (int i = 0; i < int'(len); i++) begin
                w  = fixed ? (32'hA + 32'(i)) : $urandom;
                it = '{1'b1, (base + 32'(i)) % 32'd128, w, (32'(i) == len - 32'd1), auto_st};
                q.push_back(it);
                inst_valid_i = 1'b1;
                inst_data_i  = w;
                tick();
                sum = sum + w;
                inst_valid_i = 1'b0;
                inst_data_i  = $urandom;
                repeat (gap) tick();
            end
            wait_drain();
            check("load_count", load_count_o, len);
            check("checksum", checksum_o, sum & CkMask);
            check("end_busy", {31'd0, busy_o}, 32'd0);
        end
    endtask

    task automatic abort_load(input bit use_rst);
        item_t it;
        load_start_i     = 1'b1;
        load_base_addr_i = 32'd20;
        load_len_i       = 32'd5;
        auto_start_i     = 1'b1;
        tick();
        load_start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            it = '{1'b1, 32'd20 + 32'(i), 32'h100 + 32'(i), 1'b0, 1'b1};
            q.push_back(it);
            inst_valid_i = 1'b1;
            inst_data_i  = 32'h100 + 32'(i);
            tick();
        end
        inst_data_i = 32'hDEAD;
        if (use_rst) begin
            @(negedge clk_i);
            #2;
            rst_ni = 1'b0;
            tick();
            tick();
            check_idle_clear("rst_hold");
            rst_ni = 1'b1;
        end else begin
            clr_i = 1'b1;
            tick();
            clr_i = 1'b0;
        end
        inst_valid_i = 1'b0;
        check_idle_clear(use_rst ? "rst" : "clr");
        repeat (4) tick();
        check("abort_queue", 32'(q.size()), 32'd0);
        check_idle_clear(use_rst ? "rst_late" : "clr_late");
        q.delete();
    endtask

    initial begin
        logic [31:0] b;
        logic [31:0] l;
        repeat (2) tick();
        check("rst_ready", {31'd0, inst_ready_o}, 32'd0);
        check("rst_addr", inst_wr_addr_o, 32'd0);
        check("rst_data", inst_wr_data_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check_idle_clear("rst_init");
        rst_ni = 1'b1;
        tick();

        do_load(32'd4, 32'd3, 1'b0, 0, 1'b1);
        do_load(32'd40, 32'd4, 1'b0, 1, 1'b0);
        do_load(32'd126, 32'd3, 1'b0, 0, 1'b0);
        do_load(32'd0, 32'd1, 1'b0, 0, 1'b0);
        do_load(32'd9, 32'd0, 1'b1, 0, 1'b0);
        do_load(32'd0, 32'd2, 1'b1, 0, 1'b0);
        do_load(32'd1, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        do_load(32'd125, 32'd3, 1'b1, 0, 1'b0);
        abort_load(1'b0);
        do_load(32'd7, 32'd2, 1'b0, 0, 1'b0);
        abort_load(1'b1);
        do_load(32'd60, 32'd3, 1'b1, 2, 1'b0);

        for (int k = 0; k < 30; k++) begin
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(118, 127))
                                            : 32'($urandom_range(0, 127));
            l = 32'($urandom_range(0, 9));
            do_load(b, l, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
